// File: rtl/elastic_pipeline.sv
// elastic_pipeline: chain of valid/ready register stages with bubble collapse and flush.
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset, clears all stage valids and data
//   flush      synchronous discard of every held word, blocks both transfers this cycle
//   in_valid   upstream word present on in_data
//   in_data    upstream word
//   in_ready   block accepts in_data this cycle
//   out_valid  out_data holds a valid word
//   out_data   downstream word (last stage register)
//   out_ready  downstream accepts out_data this cycle
//   occupancy  number of stages currently holding a valid word
module elastic_pipeline #(
    parameter int BIT_WIDTH = 10,
    parameter int NUMBER_OF_STAGES = 5,
    localparam int COUNT_WIDTH = (NUMBER_OF_STAGES < 1) ? 1 : $clog2(NUMBER_OF_STAGES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [BIT_WIDTH-1:0]   in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [BIT_WIDTH-1:0]   out_data,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] occupancy
);
    if (NUMBER_OF_STAGES == 0) begin : g_pass
        assign out_valid = in_valid & !flush;
        assign out_data  = in_data;
        assign in_ready  = out_ready & !flush;
        assign occupancy = '0;
    end else begin : g_pipe
        localparam int N = NUMBER_OF_STAGES;
        logic [N-1:0]         v;
        logic [BIT_WIDTH-1:0] d [N];
        logic [N:0]           r;
        logic [N-1:0]         up_v;
        logic [BIT_WIDTH-1:0] up_d [N];
        logic [COUNT_WIDTH-1:0] cnt;
        // Ready ripples back from the output: a stage can take a word if it is
        // empty or its own word is leaving, which is what collapses bubbles.
        always_comb begin
            r[N] = out_ready;
            for (int k = N - 1; k >= 0; k--) r[k] = !v[k] | r[k+1];
        end
        always_comb begin
            up_v[0] = in_valid;
            up_d[0] = in_data;
            for (int k = 1; k < N; k++) begin
                up_v[k] = v[k-1];
                up_d[k] = d[k-1];
            end
        end
        always_comb begin
            cnt = '0;
            for (int k = 0; k < N; k++) cnt = cnt + COUNT_WIDTH'(v[k]);
        end
        // Data only loads on an actual transfer so idle stages keep their last word.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v <= '0;
                for (int k = 0; k < N; k++) d[k] <= '0;
            end else if (flush) begin
                v <= '0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (r[k]) v[k] <= up_v[k];
                    if (r[k] && up_v[k]) d[k] <= up_d[k];
                end
            end
        end
        assign in_ready  = r[0] & !flush;
        assign out_valid = v[N-1] & !flush;
        assign out_data  = d[N-1];
        assign occupancy = cnt;
    end
endmodule
